frame_buffer: RTL and testbench
===============================

FRAME_BUFFER -- requirements
Module: frame_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning sample width in bits.
REQ-002 SHALL have parameter WINDOW_SIZE_BITS, default 10, meaning log2 of the analysis window W; bank depth D = 2*W.
REQ-003 SHALL have port clk  input  1  system clock; every register updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port sample_in  input  DATA_WIDTH  incoming audio sample.
REQ-006 SHALL have port sample_valid  input  1  sample_in holds a valid sample.
REQ-007 SHALL have port sample_ready  output  1  the block accepts sample_in in this cycle.
REQ-008 SHALL have port address  input  16  read address from the difference engine, an offset into the current read bank.
REQ-009 SHALL have port data_out  output  DATA_WIDTH  registered read data.
REQ-010 SHALL have port frame_valid  output  1  a complete frame of D samples is readable.
REQ-011 SHALL have port frame_done  input  1  single-cycle pulse from the consumer that releases the current read frame.
REQ-012 SHALL have port overrun  output  1  sticky flag: sample_valid was high while sample_ready was low.

Function
REQ-013 SHALL store samples in two ping-pong banks of D words each; wr_bank and rd_bank are 1-bit pointers; full_cnt (0..2) counts completed, unreleased banks.
REQ-014 SHALL accept a sample on a cycle where sample_valid and sample_ready are both high; it writes the sample to wr_bank at wr_ptr, then increments wr_ptr.
REQ-015 SHALL, on the accept that writes wr_ptr = D-1, wrap wr_ptr to 0, toggle wr_bank, and increment full_cnt.
REQ-016 SHALL drive sample_ready = (full_cnt < 2) combinationally.
REQ-017 SHALL drive frame_valid = (full_cnt > 0).
REQ-018 SHALL, on frame_done while frame_valid is high, toggle rd_bank and decrement full_cnt.
REQ-019 SHALL ignore frame_done while frame_valid is low.
REQ-020 SHALL leave full_cnt unchanged and toggle both pointers when a bank completes and frame_done arrives in the same cycle.
REQ-021 SHALL register data_out <= rd_bank[address] on every clock edge, giving exactly 1-cycle read latency whether or not frame_valid is high.
REQ-022 SHALL return 0 on data_out when address >= D.
REQ-023 SHALL set overrun when sample_valid is high and sample_ready is low; once set, overrun clears only on reset.
REQ-024 SHALL never change the contents of the read bank while frame_valid is high, because writes target only wr_bank.
REQ-025 SHALL not require a read-during-write bypass, because wr_bank and rd_bank differ whenever frame_valid is high.

Reset
REQ-026 SHALL, while reset is low, immediately clear wr_ptr, wr_bank, rd_bank, full_cnt, data_out and overrun to 0.
REQ-027 SHALL, after reset, present sample_ready = 1 and frame_valid = 0.
REQ-028 SHALL not clear bank memory contents on reset.
REQ-029 SHALL, when reset asserts mid-frame, discard the partial frame and any completed frames.

Structure
REQ-030 SHALL take DATA_WIDTH, WINDOW_SIZE_BITS and the address width (16) from the shared pitch-detection package, alongside the diff_module constants.
REQ-031 SHALL implement each bank as one sub-module, frame_bank_ram: a single-clock simple dual-port RAM with a synchronous registered read; the block instantiates it twice.

Verification
REQ-032 SHALL cover: W=16 (D=32), push samples 1..32 -> frame_valid rises in the cycle after sample 32 is accepted; address 5 returns data_out = 6 one cycle later.
REQ-033 SHALL cover: push 64 samples with no frame_done -> sample_ready goes low after the 64th sample; sample_valid held high raises overrun, and the 65th sample is not written.
REQ-034 SHALL cover: in the full state, pulse frame_done -> sample_ready = 1 next cycle; frame_valid stays high; address 0 reads 33.
REQ-035 SHALL cover: bank completion and frame_done in the same cycle -> full_cnt stays 1 and the reads switch to the new bank's data.
REQ-036 SHALL cover: address 40 with D=32 -> data_out = 0; frame_done while frame_valid is low -> no state change.
REQ-037 SHALL cover: reset pulsed low after 10 samples -> all outputs at reset values; 32 new samples are then needed before frame_valid rises.

Source files
------------

// File: rtl/frame_buffer_pkg.sv
// Shared pitch-detection constants: sample/window geometry for the frame buffer
// and the difference-engine sizing that depends on it.
package frame_buffer_pkg;

  localparam int PD_DATA_WIDTH       = 16;
  localparam int PD_WINDOW_SIZE_BITS = 10;
  localparam int PD_ADDR_WIDTH       = 16;

  // diff_module sizing: lags span one window; accumulator holds W squared differences
  localparam int DIFF_MAX_LAG   = 1 << PD_WINDOW_SIZE_BITS;
  localparam int DIFF_ACC_WIDTH = 2 * PD_DATA_WIDTH + PD_WINDOW_SIZE_BITS;

  // Bank depth D = 2*W
  function automatic int bank_depth(input int wsb);
    return 2 << wsb;
  endfunction

endpackage

// File: rtl/frame_buffer_ram.sv
// One ping-pong bank: single-clock simple dual-port RAM, registered read.
module frame_bank_ram #(
  parameter int DW = 16,
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // Contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/frame_buffer.sv
// Ping-pong sample buffer: fills one bank while the difference engine reads the
// other; full_cnt tracks completed banks not yet released by frame_done.
module frame_buffer #(
  parameter int DATA_WIDTH       = frame_buffer_pkg::PD_DATA_WIDTH,
  parameter int WINDOW_SIZE_BITS = frame_buffer_pkg::PD_WINDOW_SIZE_BITS
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [DATA_WIDTH-1:0]                   sample_in,
  input  logic                                    sample_valid,
  output logic                                    sample_ready,
  input  logic [frame_buffer_pkg::PD_ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0]                   data_out,
  output logic                                    frame_valid,
  input  logic                                    frame_done,
  output logic                                    overrun
);
  import frame_buffer_pkg::*;

  localparam int AW = WINDOW_SIZE_BITS + 1;
  localparam int D  = bank_depth(WINDOW_SIZE_BITS);
  localparam int NB = 2;

  logic [AW-1:0]                 wr_ptr;
  logic                          wr_bank, rd_bank;
  logic [1:0]                    full_cnt;
  logic                          accept, wrap, release_frm;
  logic [NB-1:0][DATA_WIDTH-1:0] rd_data;
  logic                          rd_sel_q, zero_q;

  assign sample_ready = (full_cnt < 2'd2);
  assign frame_valid  = (full_cnt != 2'd0);
  assign accept       = sample_valid && sample_ready;
  // D is a power of two, so the last slot is all ones
  assign wrap         = accept && (&wr_ptr);
  assign release_frm  = frame_done && frame_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      full_cnt <= 2'd0;
      overrun  <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (wrap) wr_bank <= ~wr_bank;
      if (release_frm) rd_bank <= ~rd_bank;
      case ({wrap, release_frm})
        2'b10:   full_cnt <= full_cnt + 2'd1;
        2'b01:   full_cnt <= full_cnt - 2'd1;
        default: full_cnt <= full_cnt;
      endcase
      if (sample_valid && !sample_ready) overrun <= 1'b1;
    end
  end

  // Bank select and out-of-range flag ride alongside the RAM read register;
  // zero_q resets high so data_out reads 0 out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_sel_q <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      rd_sel_q <= rd_bank;
      zero_q   <= |address[PD_ADDR_WIDTH-1:AW];
    end
  end

  assign data_out = zero_q ? '0 : rd_data[rd_sel_q];

  for (genvar b = 0; b < NB; b++) begin : g_bank
    frame_bank_ram #(.DW(DATA_WIDTH), .AW(AW)) u_ram (
      .clk   (clk),
      .we    (accept && (wr_bank == 1'(b))),
      .waddr (wr_ptr),
      .wdata (sample_in),
      .raddr (address[AW-1:0]),
      .rdata (rd_data[b])
    );
  end

endmodule

// File: tb/tb_frame_buffer.sv
// Directed bench for frame_buffer with W=16 (D=32).
module tb_frame_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        sample_ready;
  logic [15:0] address;
  logic [15:0] data_out;
  logic        frame_valid;
  logic        frame_done;
  logic        overrun;

  int errors = 0;
  int checks = 0;

  frame_buffer #(.DATA_WIDTH(16), .WINDOW_SIZE_BITS(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .address      (address),
    .data_out     (data_out),
    .frame_valid  (frame_valid),
    .frame_done   (frame_done),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [15:0] v);
    sample_in = v; sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic read_at(input logic [15:0] a, output logic [15:0] d);
    address = a;
    tick();
    d = data_out;
  endtask

  task automatic test_reset();
    reset = 1'b0; sample_in = '0; sample_valid = 1'b0; address = '0; frame_done = 1'b0;
    #12;
    checks++; if (sample_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", sample_ready); end
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_fvalid got=%b want=0", frame_valid); end
    checks++; if (data_out !== 16'd0) begin errors++; $display("FAIL reset_dout got=%0d want=0", data_out); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b want=0", overrun); end
    @(negedge clk); reset = 1'b1;
    tick();
  endtask

  task automatic test_fill_first();
    logic [15:0] d;
    for (int i = 1; i <= 31; i++) push(16'(i));
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL fill_early_fvalid got=%b want=0", frame_valid); end
    push(16'd32);
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL fill_fvalid got=%b want=1", frame_valid); end
    read_at(16'd5, d);
    checks++; if (d !== 16'd6) begin errors++; $display("FAIL fill_read5 got=%0d want=6", d); end
    read_at(16'd31, d);
    checks++; if (d !== 16'd32) begin errors++; $display("FAIL fill_read31 got=%0d want=32", d); end
  endtask

  task automatic test_full_overrun();
    logic [15:0] d;
    for (int i = 33; i <= 64; i++) push(16'(i));
    checks++; if (sample_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%b want=0", sample_ready); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL full_no_overrun_yet got=%b want=0", overrun); end
    push(16'd65);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set got=%b want=1", overrun); end
    // 65 must not land in bank0[0], which is still the read bank
    read_at(16'd0, d);
    checks++; if (d !== 16'd1) begin errors++; $display("FAIL overrun_nowrite got=%0d want=1", d); end
  endtask

  task automatic test_release();
    logic [15:0] d;
    address = 16'd0; frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    checks++; if (sample_ready !== 1'b1) begin errors++; $display("FAIL release_ready got=%b want=1", sample_ready); end
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL release_fvalid got=%b want=1", frame_valid); end
    read_at(16'd0, d);
    checks++; if (d !== 16'd33) begin errors++; $display("FAIL release_read0 got=%0d want=33", d); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky got=%b want=1", overrun); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d;
    for (int i = 0; i < 31; i++) push(16'(100 + i));
    frame_done = 1'b1;
    push(16'd131);
    frame_done = 1'b0;
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL simul_fvalid got=%b want=1", frame_valid); end
    checks++; if (sample_ready !== 1'b1) begin errors++; $display("FAIL simul_ready got=%b want=1", sample_ready); end
    read_at(16'd0, d);
    checks++; if (d !== 16'd100) begin errors++; $display("FAIL simul_read0 got=%0d want=100", d); end
    read_at(16'd31, d);
    checks++; if (d !== 16'd131) begin errors++; $display("FAIL simul_read31 got=%0d want=131", d); end
  endtask

  task automatic test_oob_ignore();
    logic [15:0] d;
    read_at(16'd40, d);
    checks++; if (d !== 16'd0) begin errors++; $display("FAIL oob_read40 got=%0d want=0", d); end
    frame_done = 1'b1; tick(); frame_done = 1'b0;
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL drain_fvalid got=%b want=0", frame_valid); end
    frame_done = 1'b1; tick(); frame_done = 1'b0;
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL ignore_fvalid got=%b want=0", frame_valid); end
    checks++; if (sample_ready !== 1'b1) begin errors++; $display("FAIL ignore_ready got=%b want=1", sample_ready); end
    // rd_bank must still be 1, matching the next bank written
    for (int i = 0; i < 32; i++) push(16'(200 + i));
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL refill_fvalid got=%b want=1", frame_valid); end
    read_at(16'd0, d);
    checks++; if (d !== 16'd200) begin errors++; $display("FAIL ignore_rdbank got=%0d want=200", d); end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] d;
    for (int i = 0; i < 10; i++) push(16'(500 + i));
    reset = 1'b0; #1;
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_fvalid got=%b want=0", frame_valid); end
    checks++; if (sample_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got=%b want=1", sample_ready); end
    checks++; if (data_out !== 16'd0) begin errors++; $display("FAIL rst_mid_dout got=%0d want=0", data_out); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_mid_overrun got=%b want=0", overrun); end
    @(negedge clk); reset = 1'b1;
    tick();
    for (int i = 0; i < 31; i++) push(16'(300 + i));
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL rst_refill_early got=%b want=0", frame_valid); end
    push(16'd331);
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL rst_refill_fvalid got=%b want=1", frame_valid); end
    read_at(16'd0, d);
    checks++; if (d !== 16'd300) begin errors++; $display("FAIL rst_refill_read0 got=%0d want=300", d); end
  endtask

  initial begin
    test_reset();
    test_fill_first();
    test_full_overrun();
    test_release();
    test_back_to_back();
    test_oob_ignore();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
